// File: rtl/selecionar_ativo_pkg.sv
// Shared path-search definitions: FSM state encoding, the "no active node"
// criterion value and the width helper used for index/base sizing.
package selecionar_ativo_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    BUSCA     = 2'd1,
    CONCLUIDO = 2'd2
  } estado_t;

  // Upstream sends all-ones when no node is active; slice to the criterion width.
  localparam logic [31:0] CRITERIO_INVALIDO = '1;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/selecionar_ativo_codificador_prioridade.sv
// Lowest-set-bit priority encoder over one scan chunk of match flags.
module codificador_prioridade
  import selecionar_ativo_pkg::*;
#(
  parameter int NUM_PARALELO = 4,
  parameter int OFFSET_WIDTH = clog2_min1(NUM_PARALELO)
) (
  input  logic [NUM_PARALELO-1:0] i_match,
  output logic                    o_acerto,
  output logic [OFFSET_WIDTH-1:0] o_offset
);

  // Scanning downwards lets the lowest set bit win.
  always_comb begin
    o_acerto = |i_match;
    o_offset = '0;
    for (int k = NUM_PARALELO - 1; k >= 0; k--) begin
      if (i_match[k]) o_offset = OFFSET_WIDTH'(k);
    end
  end

endmodule

// File: rtl/selecionar_ativo.sv
// Finds the lowest-numbered active slot whose criterion equals the upstream
// minimum, scanning NUM_PARALELO slots per cycle.
module selecionar_ativo
  import selecionar_ativo_pkg::*;
#(
  parameter int NUM_NA         = 8,
  parameter int CRITERIO_WIDTH = 5,
  parameter int NUM_PARALELO   = 4,
  localparam int INDICE_WIDTH  = clog2_min1(NUM_NA)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               aa_atualizar_in,
  input  logic                               ca_pronto_in,
  input  logic [CRITERIO_WIDTH-1:0]          ca_criterio_geral_in,
  input  logic [NUM_NA-1:0]                  na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0]   na_criterio_in,
  output logic                               sa_pronto_o,
  output logic                               sa_valido_o,
  output logic [INDICE_WIDTH-1:0]            sa_indice_o
);

  localparam int BASE_WIDTH   = clog2_min1(NUM_NA + NUM_PARALELO);
  localparam int OFFSET_WIDTH = clog2_min1(NUM_PARALELO);

  estado_t                   r_estado;
  logic                      r_ca_pronto_d;
  logic [CRITERIO_WIDTH-1:0] r_alvo;
  logic [BASE_WIDTH-1:0]     r_base;
  logic                      r_sa_pronto;
  logic                      r_sa_valido;
  logic [INDICE_WIDTH-1:0]   r_sa_indice;

  logic                      w_inicio;
  logic                      w_ultimo;
  logic                      w_acerto;
  logic [NUM_PARALELO-1:0]   w_match;
  logic [OFFSET_WIDTH-1:0]   w_offset;

  assign w_inicio = ca_pronto_in & ~r_ca_pronto_d;
  assign w_ultimo = (int'(r_base) + NUM_PARALELO) >= NUM_NA;

  // Only real slot indices are enumerated, so chunk positions past NUM_NA never match.
  always_comb begin
    w_match = '0;
    for (int k = 0; k < NUM_PARALELO; k++) begin
      for (int i = 0; i < NUM_NA; i++) begin
        if ((r_base + BASE_WIDTH'(k)) == BASE_WIDTH'(i)) begin
          w_match[k] = na_ativo_in[i] &&
                       (na_criterio_in[CRITERIO_WIDTH*i +: CRITERIO_WIDTH] == r_alvo);
        end
      end
    end
  end

  codificador_prioridade #(
    .NUM_PARALELO (NUM_PARALELO),
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_codificador (
    .i_match  (w_match),
    .o_acerto (w_acerto),
    .o_offset (w_offset)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado      <= OCIOSO;
      r_ca_pronto_d <= 1'b0;
      r_alvo        <= CRITERIO_INVALIDO[CRITERIO_WIDTH-1:0];
      r_base        <= '0;
      r_sa_pronto   <= 1'b0;
      r_sa_valido   <= 1'b0;
      r_sa_indice   <= '0;
    end else begin
      r_ca_pronto_d <= ca_pronto_in;
      // Table update wins over everything, including a coincident start edge.
      if (aa_atualizar_in) begin
        r_estado    <= OCIOSO;
        r_sa_pronto <= 1'b0;
        r_sa_valido <= 1'b0;
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (w_inicio) begin
              r_alvo   <= ca_criterio_geral_in;
              r_base   <= '0;
              r_estado <= BUSCA;
            end
          end
          BUSCA: begin
            if (w_acerto) begin
              r_sa_indice <= INDICE_WIDTH'(r_base + BASE_WIDTH'(w_offset));
              r_sa_valido <= 1'b1;
              r_sa_pronto <= 1'b1;
              r_estado    <= CONCLUIDO;
            end else if (w_ultimo) begin
              r_sa_indice <= '0;
              r_sa_valido <= 1'b0;
              r_sa_pronto <= 1'b1;
              r_estado    <= CONCLUIDO;
            end else begin
              r_base <= r_base + BASE_WIDTH'(NUM_PARALELO);
            end
          end
          CONCLUIDO: begin
            if (w_inicio) begin
              r_alvo      <= ca_criterio_geral_in;
              r_base      <= '0;
              r_sa_pronto <= 1'b0;
              r_sa_valido <= 1'b0;
              r_estado    <= BUSCA;
            end
          end
          default: r_estado <= OCIOSO;
        endcase
      end
    end
  end

  assign sa_pronto_o = r_sa_pronto;
  assign sa_valido_o = r_sa_valido;
  assign sa_indice_o = r_sa_indice;

endmodule
